mike_cacheline_adaptor: RTL and testbench

- Sits directly downstream of the 2-way set-associative cache datapath: converts one 256-bit cacheline transfer (fill or writeback) into a 4-beat, 64-bit burst on the physical-memory bus.
- The cache's address mux selects the line address (cpu, way0 tag, or way1 tag) fed to this block.
- Its returned line feeds the cache's pmem_data input of the data-in mux.
- Exactly one transaction is in flight at a time.

---
 rtl/mike_cacheline_adaptor.sv | 136 +++++++++++++
 tb/tb_mike_cacheline_adaptor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mike_cacheline_adaptor.sv
// Cacheline adaptor: moves one 256-bit line as a 4-beat 64-bit burst (fill or writeback).
// Optional stall timeout with err_o when MIKE_CLA_TIMEOUT_EN is defined.
module mike_cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
`ifdef MIKE_CLA_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef MIKE_CLA_TIMEOUT_EN
  ,
  output logic               err_o
`endif
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF   = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0]  LastBeat = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] AddrMask = {ADDR_W{1'b1}} << OFF;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy;
  logic              timeout_hit;

  assign busy = (state_q == StRead) || (state_q == StWrite);

`ifdef MIKE_CLA_TIMEOUT_EN
  localparam logic [9:0] StallLimit = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] stall_q;
  logic       err_q;

  assign timeout_hit = busy && !resp_i && (stall_q == StallLimit);

  // Counts consecutive un-acked cycles; cleared by any ack and outside a burst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!busy || resp_i || timeout_hit) stall_q <= '0;
      else                                 stall_q <= stall_q + 10'd1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (write_i)     state_d = StWrite;
        else if (read_i) state_d = StRead;
      end
      StRead, StWrite: begin
        if ((resp_i && (cnt_q == LastBeat)) || timeout_hit) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          // Writeback wins over fill so a dirty victim leaves before its set is refilled.
          if (write_i) begin
            line_q <= line_i;
            addr_q <= address_i & AddrMask;
          end else if (read_i) begin
            addr_q <= address_i & AddrMask;
          end
        end
        StRead: begin
          if (resp_i) begin
            line_q[cnt_q*BURST_W +: BURST_W] <= burst_i;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrite: begin
          if (resp_i) cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    burst_o = '0;
    if (state_q == StWrite) burst_o = line_q[cnt_q*BURST_W +: BURST_W];
  end

  assign read_o    = (state_q == StRead);
  assign write_o   = (state_q == StWrite);
  assign resp_o    = (state_q == StDone);
  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_mike_cacheline_adaptor.sv
// Randomized bench for mike_cacheline_adaptor: transaction-level model of fill/writeback bursts.
module tb_mike_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef MIKE_CLA_TIMEOUT_EN
  logic         err_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mike_cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef MIKE_CLA_TIMEOUT_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One transaction from an IDLE cycle. mode: 0 ack every cycle, 1 ack every other, 2 random.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wl, input logic [255:0] rl, input int mode,
                         input bit keep_rd);
    logic         is_wr;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    bit           ack;
    bit           tog;
    int           stall;
    is_wr    = wr;
    exp_addr = {addr[31:5], 5'b0};
    exp_line = '0;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    line_i    = wl;
    step();
    if (!keep_rd) read_i = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = rand256();
    tog = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stall = 0;
      do begin
        chk("read_o", read_o, !is_wr);
        chk("write_o", write_o, is_wr);
        chk("resp_o_busy", resp_o, 1'b0);
        chk("address_o", address_o, exp_addr);
        if (is_wr) chk("burst_o", burst_o, wl[k*64 +: 64]);
        case (mode)
          0:       ack = 1'b1;
          1:       begin ack = tog; tog = !tog; end
          default: ack = ($urandom_range(0, 1) == 1);
        endcase
        if (stall >= 6) ack = 1'b1;
        resp_i  = ack;
        burst_i = ack ? rl[k*64 +: 64] : {$urandom, $urandom};
        if (ack) exp_line[k*64 +: 64] = rl[k*64 +: 64];
        step();
        stall++;
      end while (!ack);
    end
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    chk("resp_o_done", resp_o, 1'b1);
    chk("read_o_done", read_o, 1'b0);
    chk("write_o_done", write_o, 1'b0);
    if (!is_wr) chk("line_o", line_o, exp_line);
    step();
    chk("resp_o_gap", resp_o, 1'b0);
    chk("read_o_gap", read_o, 1'b0);
    chk("write_o_gap", write_o, 1'b0);
  endtask

  initial begin
    logic [255:0] fill;
    logic [255:0] wb;
    logic [31:0]  a;
    int           kind;
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'hdead_beef; line_i = '1; burst_i = '1;
    step();
    step();
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_line_o", line_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_burst_o", burst_o, '0);
    rst = 1'b1;
    step();

    // Directed fill from the example address.
    fill = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    run_txn(1'b1, 1'b0, 32'h1234_5678, '0, fill, 0, 1'b0);

    // Writeback with every-other-cycle acks.
    wb = rand256();
    run_txn(1'b0, 1'b1, $urandom, wb, '0, 1, 1'b0);

    // Simultaneous request: write first, held read follows after one idle cycle.
    a = $urandom;
    run_txn(1'b1, 1'b1, $urandom, rand256(), '0, 2, 1'b1);
    run_txn(1'b1, 1'b0, a, '0, rand256(), 2, 1'b0);

    // Reset two beats into a fill.
    read_i = 1'b1; address_i = $urandom;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      step();
    end
    resp_i = 1'b0; rst = 1'b0;
    step();
    chk("midrst_read_o", read_o, 1'b0);
    chk("midrst_resp_o", resp_o, 1'b0);
    chk("midrst_line_o", line_o, '0);
    chk("midrst_address_o", address_o, '0);
    rst = 1'b1;
    step();
    run_txn(1'b1, 1'b0, $urandom, '0, rand256(), 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, $urandom, rand256(), rand256(),
              $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
